// File: rtl/md_ctrl_if.sv
// Multiply/divide unit bus: E-stage issue, D-stage hazard query, HI/LO readout.
interface md_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, md_D,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, md_D,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers.
// Results are computed at issue, held in pending registers, and committed to
// HI/LO only when the fixed-latency busy window expires.
module md_ctrl (
    input logic        clk,
    input logic        reset,
    md_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StMulRun, StDivRun} state_e;

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               b_zero;

    assign prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a})
                  * $signed({{32{bus.src_b[31]}}, bus.src_b});
    assign prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};

    // Divisor of zero is replaced so the datapath never divides by zero; the
    // result is discarded anyway because pend_wr stays clear.
    assign b_zero = (bus.src_b == 32'd0);
    assign div_b  = b_zero ? 32'd1 : bus.src_b;
    assign quot_s = $signed(bus.src_a) / $signed(div_b);
    assign rem_s  = $signed(bus.src_a) % $signed(div_b);
    assign quot_u = bus.src_a / div_b;
    assign rem_u  = bus.src_a % div_b;

    // State register and all datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Next-state: issue from idle, count down while running, commit on cnt==1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.md_op)
                        OpMult, OpMultu: begin
                            pend_hi_d = (bus.md_op == OpMult) ? prod_s[63:32] : prod_u[63:32];
                            pend_lo_d = (bus.md_op == OpMult) ? prod_s[31:0] : prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'd5;
                            state_d   = StMulRun;
                        end
                        OpDiv, OpDivu: begin
                            pend_hi_d = (bus.md_op == OpDiv) ? rem_s : rem_u;
                            pend_lo_d = (bus.md_op == OpDiv) ? quot_s : quot_u;
                            pend_wr_d = !b_zero;
                            cnt_d     = 4'd10;
                            state_d   = StDivRun;
                        end
                        OpMthi:  hi_d = bus.src_a;
                        OpMtlo:  lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            StMulRun, StDivRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: busy is the registered run flag; stall covers a same-cycle issue.
    always_comb begin
        busy_d       = (state_d != StIdle);
        bus.busy     = busy_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.md_stall = bus.md_D & (busy_q | (bus.start & (bus.md_op >= OpMult)
                                                       & (bus.md_op <= OpDivu)));
    end
endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: vector table plus stall/ignore/reset sequences.
module tb_md_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    md_ctrl_if bus ();

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, count busy cycles after the issue edge (bounded).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        bus.md_D  = 1'b0;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10};
        vecs[4]  = '{3'd5, 32'h12345678, 32'd0, 32'h12345678, 32'd3, 0};
        vecs[5]  = '{3'd6, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[6]  = '{3'd3, 32'd5, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10};
        vecs[7]  = '{3'd4, 32'd9, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10};
        vecs[8]  = '{3'd0, 32'd11, 32'd3, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[9]  = '{3'd7, 32'd11, 32'd3, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[10] = '{3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[11] = '{3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10};
        vecs[12] = '{3'd1, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'd0, 5};
        vecs[13] = '{3'd2, 32'h80000000, 32'd2, 32'd1, 32'd0, 5};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_stall", {31'd0, bus.md_stall}, 32'd0);

        // First cycle after reset release: start must be accepted.
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b1;
        bus.md_op = 3'd6;
        bus.src_a = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("first_cycle_mtlo", bus.lo, 32'hCAFEF00D);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
        end

        // md_stall with md_D held across a mult.
        @(negedge clk);
        bus.md_D  = 1'b1;
        bus.start = 1'b1;
        bus.md_op = 3'd5;
        #1;
        check("stall_mthi_issue", {31'd0, bus.md_stall}, 32'd0);
        bus.md_op = 3'd1;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        #1;
        check("stall_issue_cycle", {31'd0, bus.md_stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("stall_busy_cycle%0d", k), {31'd0, bus.md_stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("stall_after", {31'd0, bus.md_stall}, 32'd0);
        check("stall_mult_lo", bus.lo, 32'd12);

        // Same mult with md_D low: never stalls.
        @(negedge clk);
        bus.md_D  = 1'b0;
        bus.start = 1'b1;
        #1;
        n = 0;
        if (bus.md_stall !== 1'b0) n++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.md_stall !== 1'b0) n++;
            @(posedge clk);
            #1;
        end
        check("nostall_count", n, 32'd0);

        // Div, then a mult issued in busy cycle 3 must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = 3'd4;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 30) begin
            if (n == 2) begin
                bus.start = 1'b1;
                bus.md_op = 3'd1;
                bus.src_a = 32'd3;
                bus.src_b = 32'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end
        check("ignore_busy_cycles", n, 32'd10);
        check("ignore_hi", bus.hi, 32'd2);
        check("ignore_lo", bus.lo, 32'd14);
        repeat (6) @(posedge clk);
        #1;
        check("ignore_stays_idle", {31'd0, bus.busy}, 32'd0);
        check("ignore_hi_late", bus.hi, 32'd2);

        // Reset in busy cycle 2 aborts the mult for good.
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = 3'd1;
        bus.src_a = 32'd5;
        bus.src_b = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_hi_late", bus.hi, 32'd0);
        check("abort_lo_late", bus.lo, 32'd0);

        // Reset overrides a simultaneous start.
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        bus.md_op = 3'd3;
        bus.src_a = 32'd50;
        bus.src_b = 32'd5;
        @(posedge clk);
        #1;
        check("reset_over_start", {31'd0, bus.busy}, 32'd0);
        // Released with start still high: accepted on the very next edge.
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("post_reset_accept", {31'd0, bus.busy}, 32'd1);
        n = 1;
        while (bus.busy === 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("post_reset_cycles", n, 32'd11);
        check("post_reset_lo", bus.lo, 32'd10);
        check("post_reset_hi", bus.hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
